apb_master: RTL and testbench

Initiator side of the APB data-memory bus: converts the pipeline's single-cycle memory read/write requests into two-phase APB transfers (SETUP then ACCESS), waits for the responder's `pready`, and returns read data with a one-cycle completion pulse. Sits between the execute/memory stage and the APB memory responder. Drives `psel`/`penable`/`pwrite`/`paddr`/`pwdata` instead of the stage driving them directly. Provides `busy` so the pipeline can stall.

---
 rtl/apb_master.sv | 161 ++++++++++++++++
 tb/tb_apb_master.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB initiator: turns single-cycle pipeline read/write requests into two-phase
// APB transfers (SETUP, ACCESS), waits for pready and returns a one-cycle done pulse.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT cycles of pready low (done with err=1, rdata cleared for reads).
module apb_master #(
    parameter int unsigned ADDR_W  = 6,
`ifdef APB_MASTER_TIMEOUT_EN
    parameter int unsigned TIMEOUT = 15,
`endif
    parameter int unsigned DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              pwrite_q, pwrite_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    // Value at which one more pready-low cycle makes the count reach TIMEOUT.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
`endif

    // Next-state and next-output logic; every output is derived from the next state.
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                // Write wins when both requests are raised together.
                if (req_write || req_read) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    if (req_write) begin
                        pwdata_d = req_wdata;
                    end
                    state_d = StSetup;
                end
            end
            StSetup: begin
                state_d = StAccess;
`ifdef APB_MASTER_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            StAccess: begin
                if (pready) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    err_d   = pslverr;
                    if (!pwrite_q) begin
                        rdata_d = prdata;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                end else if (wait_cnt_q == CntLast) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    if (!pwrite_q) begin
                        rdata_d = '0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        psel_d    = (state_d != StIdle);
        penable_d = (state_d == StAccess);
        busy_d    = psel_d;
    end

    // State and registered outputs; reset drops any in-flight transfer silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            rdata_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            rdata_q   <= rdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // ACCESS wait-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: transaction-level reference model, scheduled
// responder, randomized transfers. Honours APB_MASTER_TIMEOUT_EN if defined.
module tb_apb_master;

    localparam int TMO = 15;

    logic        clk;
    logic        rst;
    logic        req_read;
    logic        req_write;
    logic [5:0]  req_addr;
    logic [15:0] req_wdata;
    logic        busy;
    logic        done;
    logic [15:0] rdata;
    logic        err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [5:0]  paddr;
    logic [15:0] pwdata;
    logic [15:0] prdata;
    logic        pready;
    logic        pslverr;

    apb_master dut (
        .clk       (clk),
        .rst       (rst),
        .req_read  (req_read),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the bus registers and read-data holder should contain.
    logic [5:0]  m_paddr;
    logic [15:0] m_pwdata;
    logic        m_pwrite;
    logic [15:0] m_rdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_paddr  = '0;
        m_pwdata = '0;
        m_pwrite = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic clear_req();
        req_read  = 1'b0;
        req_write = 1'b0;
        req_addr  = 6'($urandom);
        req_wdata = 16'($urandom);
    endtask

    // One complete transfer: request, SETUP, 'waits' ACCESS wait states, completion.
    task automatic do_xfer(input logic wr, input logic rd, input logic [5:0] a,
                           input logic [15:0] wd, input int waits, input logic se,
                           input logic [15:0] rv, input string tag);
        req_write = wr;
        req_read  = rd;
        req_addr  = a;
        req_wdata = wd;
        m_paddr   = a;
        m_pwrite  = wr;
        if (wr) m_pwdata = wd;
        tick();
        // Requests raised while busy must be ignored.
        req_read  = 1'($urandom);
        req_write = 1'($urandom);
        req_addr  = 6'($urandom);
        req_wdata = 16'($urandom);
        pready    = 1'($urandom);
        prdata    = 16'($urandom);
        pslverr   = 1'($urandom);
        n_checks++;
        if ({psel, penable, busy, done, err} !== 5'b10100) begin
            n_fail++;
            $display("FAIL %s setup_ctl: got %b expected %b", tag,
                     {psel, penable, busy, done, err}, 5'b10100);
        end
        n_checks++;
        if ({paddr, pwdata, pwrite} !== {m_paddr, m_pwdata, m_pwrite}) begin
            n_fail++;
            $display("FAIL %s setup_bus: got %h/%h/%b expected %h/%h/%b", tag,
                     paddr, pwdata, pwrite, m_paddr, m_pwdata, m_pwrite);
        end
        tick();
        n_checks++;
        if ({psel, penable, busy, done, err} !== 5'b11100) begin
            n_fail++;
            $display("FAIL %s access_ctl: got %b expected %b", tag,
                     {psel, penable, busy, done, err}, 5'b11100);
        end
        for (int k = 0; k <= waits; k++) begin
            pready  = (k == waits);
            prdata  = (k == waits) ? rv : 16'($urandom);
            pslverr = (k == waits) ? se : 1'($urandom);
            tick();
            if (k < waits) begin
                n_checks++;
                if ({psel, penable, busy, done, err} !== 5'b11100) begin
                    n_fail++;
                    $display("FAIL %s wait_ctl: got %b expected %b", tag,
                             {psel, penable, busy, done, err}, 5'b11100);
                end
            end else begin
                if (!m_pwrite) m_rdata = rv;
                n_checks++;
                if ({psel, penable, busy, done, err} !== {4'b0001, se}) begin
                    n_fail++;
                    $display("FAIL %s done_ctl: got %b expected %b", tag,
                             {psel, penable, busy, done, err}, {4'b0001, se});
                end
                n_checks++;
                if (rdata !== m_rdata) begin
                    n_fail++;
                    $display("FAIL %s rdata: got %h expected %h", tag, rdata, m_rdata);
                end
            end
            n_checks++;
            if ({paddr, pwdata, pwrite} !== {m_paddr, m_pwdata, m_pwrite}) begin
                n_fail++;
                $display("FAIL %s bus_hold: got %h/%h/%b expected %h/%h/%b", tag,
                         paddr, pwdata, pwrite, m_paddr, m_pwdata, m_pwrite);
            end
        end
        clear_req();
        pready  = 1'b0;
        pslverr = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            n_checks++;
            if ({psel, penable, busy, done, err} !== 5'b00000 || rdata !== m_rdata ||
                {paddr, pwdata, pwrite} !== {m_paddr, m_pwdata, m_pwrite}) begin
                n_fail++;
                $display("FAIL %s idle: got ctl %b rdata %h bus %h/%h/%b expected 00000 %h %h/%h/%b",
                         tag, {psel, penable, busy, done, err}, rdata, paddr, pwdata, pwrite,
                         m_rdata, m_paddr, m_pwdata, m_pwrite);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({psel, penable, pwrite, paddr, pwdata, rdata, done, err, busy} !== 44'd0) begin
            n_fail++;
            $display("FAIL %s all_zero: got %h expected 0", tag,
                     {psel, penable, pwrite, paddr, pwdata, rdata, done, err, busy});
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_req();
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all_zero("reset_async");
        tick();
        tick();
        check_all_zero("reset_held");
        rst = 1'b0;
        idle_cycles(2, "reset_release");
    endtask

    task automatic test_write_basic();
        do_xfer(1'b1, 1'b0, 6'h05, 16'hBEEF, 0, 1'b0, 16'h0000, "write_basic");
        idle_cycles(1, "write_basic");
    endtask

    task automatic test_read_wait();
        do_xfer(1'b0, 1'b1, 6'h12, 16'h0000, 2, 1'b0, 16'h1234, "read_wait");
        idle_cycles(3, "read_hold");
    endtask

    task automatic test_both_err();
        do_xfer(1'b1, 1'b1, 6'h2A, 16'h5A5A, 1, 1'b1, 16'hFFFF, "both_req_err");
        n_checks++;
        if (pwrite !== 1'b1) begin
            n_fail++;
            $display("FAIL both_req pwrite: got %b expected 1", pwrite);
        end
        idle_cycles(1, "both_req_err");
    endtask

    task automatic test_back_to_back();
        logic [5:0]  a;
        logic [15:0] pv;
        logic [3:0]  exp_ctl;
        int          n_done;
        a         = 6'($urandom);
        n_done    = 0;
        req_read  = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        m_paddr   = a;
        m_pwrite  = 1'b0;
        pready    = 1'b1;
        pslverr   = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            pv     = 16'($urandom);
            prdata = pv;
            tick();
            if (k % 3 == 1)      exp_ctl = 4'b1010;
            else if (k % 3 == 2) exp_ctl = 4'b1110;
            else begin
                exp_ctl = 4'b0001;
                m_rdata = pv;
            end
            if (done === 1'b1) n_done++;
            n_checks++;
            if ({psel, penable, busy, done} !== exp_ctl) begin
                n_fail++;
                $display("FAIL b2b ctl cycle %0d: got %b expected %b", k,
                         {psel, penable, busy, done}, exp_ctl);
            end
            n_checks++;
            if (rdata !== m_rdata || paddr !== m_paddr) begin
                n_fail++;
                $display("FAIL b2b data cycle %0d: got %h/%h expected %h/%h", k,
                         rdata, paddr, m_rdata, m_paddr);
            end
        end
        n_checks++;
        if (n_done != 4) begin
            n_fail++;
            $display("FAIL b2b done_count: got %0d expected 4", n_done);
        end
        clear_req();
        pready = 1'b0;
        idle_cycles(2, "b2b_end");
    endtask

    task automatic test_reset_mid();
        req_read = 1'b1;
        req_addr = 6'h33;
        tick();
        clear_req();
        pready = 1'b0;
        tick();
        n_checks++;
        if ({psel, penable} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_mid in_access: got %b expected 11", {psel, penable});
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all_zero("rst_mid_async");
        pready = 1'b1;
        tick();
        check_all_zero("rst_mid_held");
        rst    = 1'b0;
        pready = 1'b0;
        idle_cycles(2, "rst_mid_no_done");
        do_xfer(1'b0, 1'b1, 6'h21, 16'h0, 1, 1'b0, 16'hC0DE, "rst_mid_fresh");
        idle_cycles(1, "rst_mid_fresh");
    endtask

    task automatic test_random();
        int op;
        for (int t = 0; t < 16; t++) begin
            op = int'($urandom_range(0, 2));
            do_xfer(op != 0, op != 1, 6'($urandom), 16'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom), 16'($urandom), "random");
            idle_cycles(int'($urandom_range(0, 2)), "random_gap");
        end
    endtask

    task automatic test_stuck();
        req_read = 1'b1;
        req_addr = 6'h3C;
        m_paddr  = 6'h3C;
        m_pwrite = 1'b0;
        tick();
        clear_req();
        pready = 1'b0;
        tick();
`ifdef APB_MASTER_TIMEOUT_EN
        for (int k = 1; k <= TMO; k++) begin
            prdata  = 16'($urandom);
            pslverr = 1'($urandom);
            tick();
            if (k < TMO) begin
                n_checks++;
                if ({psel, penable, busy, done} !== 4'b1110) begin
                    n_fail++;
                    $display("FAIL timeout wait %0d: got %b expected 1110", k,
                             {psel, penable, busy, done});
                end
            end else begin
                m_rdata = '0;
                n_checks++;
                if ({psel, penable, busy, done, err} !== 5'b00011 || rdata !== m_rdata) begin
                    n_fail++;
                    $display("FAIL timeout done: got %b rdata %h expected 00011 rdata %h",
                             {psel, penable, busy, done, err}, rdata, m_rdata);
                end
            end
        end
        pslverr = 1'b0;
        idle_cycles(2, "timeout_after");
`else
        for (int k = 1; k <= 100; k++) begin
            prdata  = 16'($urandom);
            pslverr = 1'($urandom);
            tick();
            n_checks++;
            if ({psel, penable, busy, done, err} !== 5'b11100) begin
                n_fail++;
                $display("FAIL stuck cycle %0d: got %b expected 11100", k,
                         {psel, penable, busy, done, err});
            end
        end
        pslverr = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        tick();
        rst = 1'b0;
        check_all_zero("stuck_recover");
`endif
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_both_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_stuck();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
